// File: rtl/ram_loader.sv
// Program loader: writes a framed, checksummed byte stream into RAM
// while holding the CPU in halt.
module ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, CSUM, DONE, ERR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    // One extra bit so a zero length byte can encode a full 2^DATA_WIDTH run
    logic [DATA_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] acc;
    logic                  accept;

    assign in_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
    assign cpu_hold  = in_ready || (state == ERR);
    assign load_done = (state == DONE);
    assign accept    = in_valid && in_ready && !load_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            remaining    <= '0;
            acc          <= '0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            load_err     <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            unique case (state)
                IDLE, ERR: begin
                    if (load_start) begin
                        state    <= LEN;
                        load_err <= 1'b0;
                        acc      <= '0;
                        ptr      <= BASE_ADDR;
                    end
                end
                LEN: begin
                    if (load_abort) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end else if (accept) begin
                        if (in_data == '0)
                            remaining <= {1'b1, {DATA_WIDTH{1'b0}}};
                        else
                            remaining <= {1'b0, in_data};
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (load_abort) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end else if (accept) begin
                        mem_write_en <= 1'b1;
                        mem_addr     <= ptr;
                        mem_data     <= in_data;
                        ptr          <= ptr + ADDR_WIDTH'(1);
                        acc          <= acc + in_data;
                        remaining    <= remaining - (DATA_WIDTH + 1)'(1);
                        if (remaining == (DATA_WIDTH + 1)'(1))
                            state <= CSUM;
                    end
                end
                CSUM: begin
                    if (load_abort) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end else if (accept) begin
                        if (in_data == acc) begin
                            state <= DONE;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Program loader that fills the CPU's unified RAM through its write port before execution begins.
- It receives a framed byte stream over a valid/ready handshake and writes the payload into RAM starting at BASE_ADDR.
- It verifies a checksum and holds the CPU in halt (cpu_hold) for the whole load.
- It sits beside the CPU top. Its mem_* outputs are muxed onto the RAM write port (address, data, write_en) while cpu_hold is high.

Parameters:
- ADDR_WIDTH, 8, RAM address width; the write pointer wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, byte width of the stream, RAM data and checksum.
- BASE_ADDR, 0, first RAM address written by a load.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  begin a load; sampled only in IDLE and ERR.
- load_abort  input  1  cancel an in-progress load.
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_write_en  output  1  RAM write strobe, one cycle per payload byte.
- mem_addr  output  ADDR_WIDTH  RAM write address.
- mem_data  output  DATA_WIDTH  RAM write data.
- cpu_hold  output  1  CPU halted / RAM port owned by loader.
- load_done  output  1  one-cycle pulse on successful load.
- load_err  output  1  sticky checksum or abort error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset state (rst low): state=IDLE. All of the following are 0: in_ready, mem_write_en, mem_addr, mem_data, cpu_hold, load_done, load_err, remaining count, checksum accumulator.
- Handshake: a byte is accepted in any cycle where in_valid and in_ready are both 1.
  - in_ready = 1 exactly in states LEN, DATA and CSUM (decoded from state).
  - Back-to-back acceptance every cycle is supported.
  - in_data is ignored when it is not accepted.
- Frame format: length byte L, then N data bytes, then checksum byte C.
  - N = L, except L=0 means N=2^DATA_WIDTH (256).
  - C must equal the sum of the N data bytes modulo 2^DATA_WIDTH.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE: load_start=1 -> LEN. Clears load_err and the accumulator; loads the write pointer with BASE_ADDR.
  - LEN: accept -> remaining=N, then go to DATA.
  - DATA: accept -> the next cycle drives mem_write_en=1, mem_addr=pointer, mem_data=byte.
    - The pointer then increments and wraps modulo 2^ADDR_WIDTH.
    - accumulator += byte (mod 2^DATA_WIDTH); remaining decrements.
    - Acceptance of the last byte (remaining=1) -> CSUM.
  - CSUM: accept -> if in_data equals the accumulator, go to DONE; otherwise go to ERR and set load_err=1.
  - DONE: load_done=1 for exactly one cycle, then go to IDLE.
  - ERR: load_err stays 1. load_start=1 -> LEN, with the same clears as from IDLE.
- Write timing:
  - Write latency is exactly 1 cycle after acceptance.
  - mem_write_en is 0 in every other cycle, and never asserts for length, checksum or discarded bytes.
  - The final payload write occurs while in CSUM, so it always completes before load_done.
- cpu_hold:
  - 1 in LEN, DATA, CSUM and ERR.
  - 0 in IDLE and DONE; it falls in the same cycle load_done rises.
- load_abort:
  - In LEN, DATA or CSUM -> ERR with load_err=1.
  - A write already scheduled for the next cycle still completes.
  - load_abort has priority over a simultaneous handshake; that byte is not accepted.
  - Ignored in IDLE, DONE and ERR.
- Ignored requests: load_start is ignored in LEN, DATA, CSUM and DONE.
- Reset mid-load: any state -> IDLE immediately. A partially written RAM is left as-is.

Test Plan:
- Basic load: reset, load_start, then stream 03,AA,BB,CC,(AA+BB+CC)&FF=31 with in_valid held high.
  - Required: writes of AA@0, BB@1, CC@2, each one cycle after acceptance.
  - Required: load_done pulses once and cpu_hold falls in that cycle; load_err=0.
- Bad checksum: frame 02,10,20,00.
  - Required: writes 10@0 and 20@1; state ERR with load_err=1, cpu_hold=1, no load_done.
  - Then load_start with a valid frame: load_err clears and the load succeeds.
- Wrap: BASE_ADDR=0xFE, frame 04,01,02,03,04,0A.
  - Required: writes to FE, FF, 00, 01; load_done pulses.
- Length 256: L=00 followed by 256 bytes of 01 and checksum 00.
  - Required: 256 writes over addresses 00..FF, then load_done.
- Throttled stream: in_valid toggled randomly.
  - Required: exactly one write per accepted data byte; in_ready stays 1 in DATA; same RAM image as the unthrottled case.
- Abort and reset: assert load_abort together with in_valid on the 2nd data byte.
  - Required: only the 1st byte is written; ERR with load_err=1.
  - Separately, rst low mid-DATA: all outputs are 0 asynchronously.
